// File: rtl/conv_window_sequencer_if.sv
// rtl/conv_window_sequencer_if.sv - control/status bundle between layer controller and tap sequencer
interface conv_window_sequencer_if #(
  parameter int STATE_W = 4,
  parameter int PASS_W  = 4
);
  logic               start;
  logic [PASS_W-1:0]  num_passes;
  logic               continuous;
  logic               enable;
  logic               abort;
  logic [STATE_W-1:0] state_out;
  logic               state_valid;
  logic               final_state_reached;
  logic [PASS_W-1:0]  pass_idx;
  logic               busy;
  logic               done;

  modport master (
    output start, num_passes, continuous, enable, abort,
    input  state_out, state_valid, final_state_reached, pass_idx, busy, done
  );

  modport slave (
    input  start, num_passes, continuous, enable, abort,
    output state_out, state_valid, final_state_reached, pass_idx, busy, done
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - multi-pass kernel tap sequencer with start/busy/done, stall and abort
module conv_window_sequencer #(
  parameter int NUM_STATES = 9,
  parameter int STATE_W    = 4,
  parameter int PASS_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_window_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [STATE_W-1:0] LAST_TAP = STATE_W'(NUM_STATES - 1);
  localparam logic [PASS_W-1:0]  ONE_PASS = PASS_W'(1);

  logic [1:0]         r_fsm;
  logic [STATE_W-1:0] r_tap;
  logic [PASS_W-1:0]  r_pass;
  logic [PASS_W-1:0]  r_passes;
  logic               r_valid;
  logic               r_final;
  logic               r_busy;
  logic               r_done;

  logic [STATE_W-1:0] w_tap_inc;
  logic [PASS_W-1:0]  w_passes_in;
  logic               w_last_tap;
  logic               w_last_pass;

  assign w_tap_inc   = r_tap + STATE_W'(1);
  assign w_last_tap  = (r_tap == LAST_TAP);
  assign w_last_pass = (r_pass == (r_passes - ONE_PASS));
  // A zero pass count still runs one sweep.
  assign w_passes_in = (bus.num_passes == '0) ? ONE_PASS : bus.num_passes;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm    <= S_IDLE;
      r_tap    <= '0;
      r_pass   <= '0;
      r_passes <= ONE_PASS;
      r_valid  <= 1'b0;
      r_final  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_fsm    <= S_RUN;
            r_passes <= w_passes_in;
            r_tap    <= '0;
            r_pass   <= '0;
            r_valid  <= 1'b1;
            r_final  <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end

        S_RUN: begin
          if (bus.abort) begin
            r_fsm    <= S_IDLE;
            r_tap    <= '0;
            r_pass   <= '0;
            r_passes <= ONE_PASS;
            r_valid  <= 1'b0;
            r_final  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end else if (bus.enable) begin
            if (w_last_tap) begin
              r_tap   <= '0;
              r_final <= 1'b0;
              if (!w_last_pass) begin
                r_pass <= r_pass + ONE_PASS;
              end else if (bus.continuous) begin
                r_pass <= '0;
              end else begin
                r_fsm   <= S_DONE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_tap   <= w_tap_inc;
              r_final <= (w_tap_inc == LAST_TAP);
            end
          end
        end

        S_DONE: begin
          // Single-cycle completion; start is deliberately not honoured here.
          r_fsm    <= S_IDLE;
          r_tap    <= '0;
          r_pass   <= '0;
          r_passes <= ONE_PASS;
          r_valid  <= 1'b0;
          r_final  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end

        default: begin
          r_fsm   <= S_IDLE;
          r_tap   <= '0;
          r_pass  <= '0;
          r_valid <= 1'b0;
          r_final <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_out           = r_tap;
  assign bus.state_valid         = r_valid;
  assign bus.final_state_reached = r_final;
  assign bus.pass_idx            = r_pass;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed self-checking bench for conv_window_sequencer
module tb_conv_window_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  conv_window_sequencer_if #(.STATE_W(4), .PASS_W(4)) if_a ();
  conv_window_sequencer_if #(.STATE_W(5), .PASS_W(4)) if_b ();

  conv_window_sequencer #(.NUM_STATES(9), .STATE_W(4), .PASS_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  conv_window_sequencer #(.NUM_STATES(25), .STATE_W(5), .PASS_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int tap, input int vld, input int fin,
                       input int pass, input int bsy, input int dn);
    chk({tag, ".state_out"}, 32'(if_a.state_out), tap);
    chk({tag, ".state_valid"}, 32'(if_a.state_valid), vld);
    chk({tag, ".final"}, 32'(if_a.final_state_reached), fin);
    chk({tag, ".pass_idx"}, 32'(if_a.pass_idx), pass);
    chk({tag, ".busy"}, 32'(if_a.busy), bsy);
    chk({tag, ".done"}, 32'(if_a.done), dn);
  endtask

  task automatic chk_b(input string tag, input int tap, input int vld, input int fin,
                       input int pass, input int bsy, input int dn);
    chk({tag, ".state_out"}, 32'(if_b.state_out), tap);
    chk({tag, ".state_valid"}, 32'(if_b.state_valid), vld);
    chk({tag, ".final"}, 32'(if_b.final_state_reached), fin);
    chk({tag, ".pass_idx"}, 32'(if_b.pass_idx), pass);
    chk({tag, ".busy"}, 32'(if_b.busy), bsy);
    chk({tag, ".done"}, 32'(if_b.done), dn);
  endtask

  initial begin
    int et, ep, stalls, fin_m;
    logic en, cont;

    reset = 1'b1;
    if_a.start = 0; if_a.num_passes = 0; if_a.continuous = 0; if_a.enable = 0; if_a.abort = 0;
    if_b.start = 0; if_b.num_passes = 0; if_b.continuous = 0; if_b.enable = 0; if_b.abort = 0;
    tick(); tick();
    chk_a("reset_a", 0, 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_a("idle_a", 0, 0, 0, 0, 0, 0);

    // Scenario 1: single pass
    if_a.num_passes = 1; if_a.enable = 1; if_a.start = 1;
    tick();
    if_a.start = 0;
    for (int k = 0; k < 9; k++) begin
      chk_a($sformatf("s1_k%0d", k), k, 1, (k == 8) ? 1 : 0, 0, 1, 0);
      tick();
    end
    chk_a("s1_done", 0, 0, 0, 0, 1, 1);
    tick();
    chk_a("s1_idle", 0, 0, 0, 0, 0, 0);

    // Scenario 2: three passes
    if_a.num_passes = 3; if_a.start = 1;
    tick();
    if_a.start = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 9; k++) begin
        chk_a($sformatf("s2_p%0d_k%0d", p, k), k, 1, (k == 8) ? 1 : 0, p, 1, 0);
        tick();
      end
    end
    chk_a("s2_done", 0, 0, 0, 2, 1, 1);
    tick();
    chk_a("s2_idle", 0, 0, 0, 0, 0, 0);

    // Scenario 3: enable pattern 1,0,0 repeating
    if_a.num_passes = 1; if_a.start = 1;
    tick();
    if_a.start = 0;
    et = 0; stalls = 0; fin_m = 0;
    for (int c = 0; c < 100 && fin_m == 0; c++) begin
      chk_a($sformatf("s3_c%0d", c), et, 1, (et == 8) ? 1 : 0, 0, 1, 0);
      en = ((c % 3) == 0);
      if_a.enable = en;
      tick();
      if (en) begin
        if (et == 8) fin_m = 1;
        else et++;
      end else begin
        stalls++;
      end
    end
    if_a.enable = 1;
    chk("s3_stall_count", 32'(stalls), 32'd16);
    chk_a("s3_done", 0, 0, 0, 0, 1, 1);
    tick();
    chk_a("s3_idle", 0, 0, 0, 0, 0, 0);

    // Scenario 4: continuous with two passes, released after 40 cycles
    if_a.num_passes = 2; if_a.continuous = 1; if_a.start = 1;
    tick();
    if_a.start = 0;
    et = 0; ep = 0; fin_m = 0;
    for (int c = 0; c < 120 && fin_m == 0; c++) begin
      if (c == 40) if_a.continuous = 0;
      cont = if_a.continuous;
      chk_a($sformatf("s4_c%0d", c), et, 1, (et == 8) ? 1 : 0, ep, 1, 0);
      tick();
      if (et == 8) begin
        et = 0;
        if (ep < 1) ep++;
        else if (cont) ep = 0;
        else fin_m = 1;
      end else begin
        et++;
      end
    end
    chk_a("s4_done", 0, 0, 0, 1, 1, 1);
    tick();
    chk_a("s4_idle", 0, 0, 0, 0, 0, 0);

    // Scenario 5: ignored start in RUN, abort at pass 1 tap 4
    if_a.num_passes = 2; if_a.start = 1;
    tick();
    if_a.start = 0;
    for (int c = 0; c < 13; c++) begin
      if_a.start = (c == 3);
      tick();
    end
    if_a.start = 0;
    chk_a("s5_pre_abort", 4, 1, 0, 1, 1, 0);
    if_a.abort = 1;
    tick();
    if_a.abort = 0;
    chk_a("s5_aborted", 0, 0, 0, 0, 0, 0);
    tick();
    chk_a("s5_no_done", 0, 0, 0, 0, 0, 0);
    if_a.abort = 1; if_a.start = 1;
    tick();
    if_a.abort = 0; if_a.start = 0;
    chk_a("s5_abort_beats_start", 0, 0, 0, 0, 0, 0);
    if_a.num_passes = 1; if_a.start = 1;
    tick();
    if_a.start = 0;
    for (int k = 0; k < 9; k++) tick();
    chk_a("s5_done", 0, 0, 0, 0, 1, 1);
    if_a.start = 1;
    tick();
    if_a.start = 0;
    chk_a("s5_start_in_done_ignored", 0, 0, 0, 0, 0, 0);
    if_a.start = 1;
    tick();
    if_a.start = 0;
    for (int k = 0; k < 9; k++) begin
      chk_a($sformatf("s5_replay_k%0d", k), k, 1, (k == 8) ? 1 : 0, 0, 1, 0);
      tick();
    end
    chk_a("s5_replay_done", 0, 0, 0, 0, 1, 1);
    tick();
    chk_a("s5_replay_idle", 0, 0, 0, 0, 0, 0);

    // Scenario 6: 25 taps, num_passes=0 runs once; reset mid-run
    if_b.num_passes = 0; if_b.enable = 1; if_b.start = 1;
    tick();
    if_b.start = 0;
    for (int k = 0; k < 25; k++) begin
      chk_b($sformatf("s6_k%0d", k), k, 1, (k == 24) ? 1 : 0, 0, 1, 0);
      tick();
    end
    chk_b("s6_done", 0, 0, 0, 0, 1, 1);
    tick();
    chk_b("s6_idle", 0, 0, 0, 0, 0, 0);
    if_b.start = 1;
    tick();
    if_b.start = 0;
    for (int k = 0; k < 12; k++) tick();
    chk_b("s6_pre_reset", 12, 1, 0, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_b("s6_reset", 0, 0, 0, 0, 0, 0);
    tick();
    chk_b("s6_post_reset", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Parametrised successor of the 9-state convolution-window sequencer.
- Steps a state index 0..NUM_STATES-1 once per enabled cycle. Repeats that sweep for a run-time number of passes, then signals completion.
- Adds a start/busy/done handshake, stall via enable, an abort, and a free-running mode.
- Sits between the layer controller and the window/weight address generators; state_out selects the kernel tap.

Parameters:
- NUM_STATES, 9, states per pass (kernel taps); legal range >= 2.
- STATE_W, 4, width of state_out; must satisfy 2**STATE_W >= NUM_STATES.
- PASS_W, 4, width of num_passes and pass_idx.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high; overrides every other input.
- start  input  1  request a job; sampled only in IDLE.
- num_passes  input  PASS_W  passes per job; latched on accepted start; value 0 is treated as 1.
- continuous  input  1  1 = wrap pass_idx forever and never finish; sampled on every pass-final beat.
- enable  input  1  1 = current beat retires and the sequence advances; 0 = hold.
- abort  input  1  return to IDLE next cycle, no done.
- state_out  output  STATE_W  current tap index.
- state_valid  output  1  high in RUN.
- final_state_reached  output  1  high in RUN while state_out == NUM_STATES-1.
- pass_idx  output  PASS_W  current pass number, 0-based.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- All outputs are registered.
- Reset values: state_out=0, state_valid=0, final_state_reached=0, pass_idx=0, busy=0, done=0, FSM=IDLE, latched pass count=1.
- A reset asserted mid-run takes effect at the next edge; no done is produced.

FSM states:
- IDLE:
  - All status outputs are 0.
  - start=1 latches max(num_passes,1), clears state_out and pass_idx, and enters RUN.
  - First valid beat (state_valid=1, state_out=0) appears on the cycle after start is sampled.
- RUN, enable=1:
  - If state_out < NUM_STATES-1: state_out increments.
  - If state_out == NUM_STATES-1 (pass-final beat), state_out wraps to 0, then:
    - pass_idx < latched-1: pass_idx increments.
    - pass_idx == latched-1 and continuous=1: pass_idx wraps to 0; stay in RUN.
    - pass_idx == latched-1 and continuous=0: go to DONE.
- RUN, enable=0: every output holds, including final_state_reached.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, state_valid=0, final_state_reached=0.
  - Then IDLE with state_out=0 and pass_idx=0.
- Ignored inputs:
  - start outside IDLE, including in DONE; there is no back-to-back restart, and the earliest new start is sampled in IDLE.
  - num_passes changes after the start is accepted.
- abort:
  - In RUN or DONE, the next state is IDLE and outputs take their reset values (done stays 0).
  - abort has priority over enable and over the pass-final transition.
  - abort in IDLE has no effect; abort and start together in IDLE: abort wins and the job is not accepted.
- Timing: with enable held at 1 and start sampled at cycle T, state_out=k at cycle T+1+p*NUM_STATES+k.
  - final_state_reached is high at k=NUM_STATES-1.
  - done is at cycle T+1+P*NUM_STATES for P passes.
- Arithmetic: state_out and pass_idx are unsigned; the wrap is explicit at NUM_STATES-1 and latched-1, not by modulo 2**W.

Test Plan:
1. Default params, num_passes=1, enable=1, start pulse at T -> state_out 0..8 at T+1..T+9; final_state_reached only at T+9; done pulse at T+10; busy T+1..T+10; IDLE at T+11.
2. num_passes=3, enable=1 -> pass_idx 0,1,2, each for 9 cycles; final_state_reached three times; a single done at T+28.
3. enable toggles 1,0,0,1,... during RUN -> state_out holds on stalled cycles; when a stall occurs at state 8, final_state_reached stays high across the stall; done is delayed by exactly the number of stall cycles.
4. continuous=1, num_passes=2, run 40 cycles, then continuous=0 -> pass_idx cycles 0,1,0,1,...; done follows the first pass-final beat with pass_idx=1 after the deassertion.
5. abort at state_out=4 of pass 1, num_passes=2 -> next cycle: all outputs 0 and no done. start re-pulsed during RUN and in DONE is ignored; a fresh start then replays scenario 1 timing.
6. NUM_STATES=25, STATE_W=5, num_passes=0 -> exactly one pass, 0..24; final_state_reached at state 24; done 26 cycles after start is sampled. Reset asserted at state 12 -> reset values at the next edge.
